// File: rtl/car_ctrl_pkg.sv
// Encodings and default constants shared by the speed-limit arbiter and the
// control unit's testbench.
package car_ctrl_pkg;

  localparam logic [7:0] DEFAULT_LIMIT_KMH = 8'd80;
  localparam logic [7:0] STEP_KMH          = 8'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_DRV  = 2'b01,
    OWN_SIGN = 2'b10,
    OWN_EMG  = 2'b11
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    EMERG = 2'd2
  } state_t;

  // One slew step from cur toward tgt; lands exactly on tgt when closer than step.
  function automatic logic [7:0] slew_step(input logic [7:0] cur,
                                           input logic [7:0] tgt,
                                           input logic [7:0] step);
    logic [7:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > step) ? cur + step : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > step) ? cur - step : tgt;
    end
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Ramp tick generator: one-cycle pulse every TICK_DIV cycles, phase restarted
// by clear.
module tick_divider #(
  parameter logic [15:0] TICK_DIV = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  logic [15:0] count;

  assign tick = (count == TICK_DIV - 16'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/speed_limit_arbiter.sv
// Arbitrates driver, road-sign and emergency speed-limit requests and slews the
// limit presented to the control unit.
module speed_limit_arbiter
  import car_ctrl_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_LIMIT = DEFAULT_LIMIT_KMH,
  parameter logic [7:0]  STEP          = STEP_KMH,
  parameter logic [15:0] TICK_DIV      = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       drv_req,
  input  logic [7:0] drv_limit,
  input  logic       sign_req,
  input  logic [7:0] sign_limit,
  input  logic       emg_req,
  input  logic [7:0] emg_limit,
  output logic       drv_ack,
  output logic       sign_ack,
  output logic       emg_ack,
  output logic [7:0] speed_limit,
  output logic [1:0] owner,
  output logic       busy
);

  state_t     state;
  owner_t     owner_q;
  owner_t     gnt;
  logic [7:0] target;
  logic [7:0] gnt_limit;
  logic [7:0] next_target;
  logic [7:0] advanced;
  logic       drv_pend;
  logic       sign_pend;
  logic       emg_pend;
  logic       tick;
  logic       clear;

  // A request whose ack is high this cycle is the one just granted; ignore it.
  assign drv_pend  = drv_req  & ~drv_ack;
  assign sign_pend = sign_req & ~sign_ack;
  assign emg_pend  = emg_req  & ~emg_ack;

  assign owner = owner_q;

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it
    // unassigned, which would infer a latch.
    gnt = OWN_NONE;
    case (state)
      IDLE: begin
        if (emg_pend)       gnt = OWN_EMG;
        else if (sign_pend) gnt = OWN_SIGN;
        else if (drv_pend)  gnt = OWN_DRV;
      end
      RAMP: begin
        if (emg_pend)                              gnt = OWN_EMG;
        else if (sign_pend && owner_q == OWN_DRV)  gnt = OWN_SIGN;
      end
      default: gnt = OWN_NONE;
    endcase
  end

  always_comb begin
    gnt_limit = drv_limit;
    case (gnt)
      OWN_SIGN: gnt_limit = sign_limit;
      OWN_EMG:  gnt_limit = emg_limit;
      default:  gnt_limit = drv_limit;
    endcase
  end

  // A preemption retargets first; a tick on the same edge steps toward the new target.
  assign next_target = (gnt == OWN_NONE) ? target : gnt_limit;
  assign advanced    = tick ? slew_step(speed_limit, next_target, STEP) : speed_limit;
  assign clear       = (state == IDLE) && (gnt != OWN_NONE);

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_q     <= OWN_NONE;
      target      <= DEFAULT_LIMIT;
      speed_limit <= DEFAULT_LIMIT;
      busy        <= 1'b0;
      drv_ack     <= 1'b0;
      sign_ack    <= 1'b0;
      emg_ack     <= 1'b0;
    end else begin
      drv_ack  <= (gnt == OWN_DRV);
      sign_ack <= (gnt == OWN_SIGN);
      emg_ack  <= (gnt == OWN_EMG);
      if (gnt != OWN_NONE) begin
        target  <= gnt_limit;
        owner_q <= gnt;
      end
      case (state)
        IDLE: begin
          if (gnt == OWN_NONE) begin
            owner_q <= OWN_NONE;
          end else if (gnt == OWN_EMG) begin
            state <= EMERG;
            if (emg_limit < speed_limit) speed_limit <= emg_limit;
            busy <= (emg_limit > speed_limit);
          end else if (gnt_limit != speed_limit) begin
            state <= RAMP;
            busy  <= 1'b1;
          end
        end
        RAMP: begin
          if (gnt == OWN_EMG && emg_limit < speed_limit) begin
            state       <= EMERG;
            speed_limit <= emg_limit;
            busy        <= 1'b0;
          end else begin
            speed_limit <= advanced;
            if (gnt == OWN_EMG) begin
              state <= EMERG;
              busy  <= (advanced != next_target);
            end else if (advanced == next_target) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        EMERG: begin
          // Release abandons any unfinished upward ramp and holds the limit.
          if (!emg_req && !emg_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            speed_limit <= advanced;
            busy        <= (advanced != target);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speed_limit_arbiter.sv
// Directed scenarios plus randomized requesters, checked every cycle against a
// behavioural model of the arbitration and slew rules.
module tb_speed_limit_arbiter;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 2;
  localparam int DEF      = 80;
  localparam int M_IDLE   = 0;
  localparam int M_RAMP   = 1;
  localparam int M_EMG    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drv_req = 1'b0, sign_req = 1'b0, emg_req = 1'b0;
  logic [7:0] drv_limit = 8'd0, sign_limit = 8'd0, emg_limit = 8'd0;
  logic       drv_ack, sign_ack, emg_ack, busy;
  logic [7:0] speed_limit;
  logic [1:0] owner;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state
  int       m_speed, m_target, m_owner, m_mode;
  bit       m_busy;
  bit [2:0] m_ack;
  int       edge_no, clr_edge;
  int       emg_left;

  speed_limit_arbiter #(
    .DEFAULT_LIMIT(8'd80),
    .STEP         (8'd2),
    .TICK_DIV     (16'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .drv_req    (drv_req),
    .drv_limit  (drv_limit),
    .sign_req   (sign_req),
    .sign_limit (sign_limit),
    .emg_req    (emg_req),
    .emg_limit  (emg_limit),
    .drv_ack    (drv_ack),
    .sign_ack   (sign_ack),
    .emg_ack    (emg_ack),
    .speed_limit(speed_limit),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (tgt - cur > STEP) return cur + STEP;
    if (cur - tgt > STEP) return cur - STEP;
    return tgt;
  endfunction

  task automatic model_reset();
    m_speed = DEF; m_target = DEF; m_owner = 0; m_mode = M_IDLE;
    m_busy = 1'b0; m_ack = 3'b000; edge_no = 0; clr_edge = 0;
  endtask

  // One rising edge of the arbitration rules, using the inputs held across it.
  task automatic model_step();
    int win, lim;
    bit tick, emg_was_acked;
    edge_no++;
    tick = ((edge_no - clr_edge) % TICK_DIV) == 0;
    win = 0;
    if (m_mode == M_IDLE) begin
      if (emg_req && !m_ack[2])       win = 3;
      else if (sign_req && !m_ack[1]) win = 2;
      else if (drv_req && !m_ack[0])  win = 1;
    end else if (m_mode == M_RAMP) begin
      if (emg_req && !m_ack[2])                        win = 3;
      else if (sign_req && !m_ack[1] && m_owner == 1)  win = 2;
    end
    lim = (win == 3) ? int'(emg_limit) : (win == 2) ? int'(sign_limit) : int'(drv_limit);
    emg_was_acked = m_ack[2];
    m_ack = 3'b000;
    if (win != 0) begin
      m_ack[win-1] = 1'b1;
      m_owner = win;
      m_target = lim;
    end
    if (m_mode == M_IDLE) begin
      if (win == 0) begin
        m_owner = 0;
      end else begin
        clr_edge = edge_no;
        if (win == 3) begin
          m_mode = M_EMG;
          if (lim < m_speed) m_speed = lim;
          m_busy = (lim != m_speed);
        end else if (lim != m_speed) begin
          m_mode = M_RAMP;
          m_busy = 1'b1;
        end
      end
    end else if (m_mode == M_RAMP) begin
      if (win == 3 && lim < m_speed) begin
        m_speed = lim; m_busy = 1'b0; m_mode = M_EMG;
      end else begin
        if (tick) m_speed = toward(m_speed, m_target);
        if (win == 3) begin
          m_mode = M_EMG;
          m_busy = (m_speed != m_target);
        end else if (m_speed == m_target) begin
          m_mode = M_IDLE;
          m_busy = 1'b0;
        end
      end
    end else begin
      if (!emg_req && !emg_was_acked) begin
        m_mode = M_IDLE;
        m_busy = 1'b0;
      end else begin
        if (tick) m_speed = toward(m_speed, m_target);
        m_busy = (m_speed != m_target);
      end
    end
  endtask

  // Advance one clock, check all outputs, and let granted requesters release.
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("speed_limit", speed_limit, m_speed);
    check("owner", owner, m_owner);
    check("busy", busy, m_busy);
    check("acks", {emg_ack, sign_ack, drv_ack}, m_ack);
    if (m_ack[0]) drv_req = 1'b0;
    if (m_ack[1]) sign_req = 1'b0;
  endtask

  // Called at a falling edge; outputs must show reset values before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    drv_req = 1'b0; sign_req = 1'b0; emg_req = 1'b0; emg_left = 0;
    model_reset();
    #1;
    check("rst_speed", speed_limit, 8'd80);
    check("rst_owner", owner, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {emg_ack, sign_ack, drv_ack}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    bit settled = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_mode == M_IDLE && !m_busy && !drv_req && !sign_req) begin
        settled = 1'b1;
        break;
      end
      run_cycle();
    end
    if (!settled) settled = (m_mode == M_IDLE && !m_busy && !drv_req && !sign_req);
    check("settle_timeout", settled, 1'b1);
  endtask

  task automatic wait_ack(input int idx, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      run_cycle();
      seen = m_ack[idx];
    end
    check("ack_timeout", seen, 1'b1);
  endtask

  initial begin
    model_reset();
    emg_left = 0;
    @(negedge clk);
    do_reset();

    // Driver ramp 80 -> 90, one step of 2 every 4 cycles.
    drv_req = 1'b1; drv_limit = 8'd90;
    run_cycle();
    check("drv_grant", drv_ack, 1'b1);
    repeat (19) run_cycle();
    check("drv_ramp_88", speed_limit, 8'd88);
    run_cycle();
    check("drv_ramp_90", speed_limit, 8'd90);
    check("drv_ramp_busy", busy, 1'b0);
    run_cycle();
    check("drv_owner_none", owner, 2'b00);

    // Sign preempts a driver ramp at 84; a new driver request waits for IDLE.
    do_reset();
    drv_req = 1'b1; drv_limit = 8'd90;
    run_cycle();
    repeat (8) run_cycle();
    check("preempt_at_84", speed_limit, 8'd84);
    sign_req = 1'b1; sign_limit = 8'd60;
    run_cycle();
    check("sign_preempt_ack", sign_ack, 1'b1);
    check("sign_preempt_owner", owner, 2'b10);
    drv_req = 1'b1; drv_limit = 8'd70;
    wait_ack(0, 200);
    check("drv_after_sign", speed_limit, 8'd60);
    run_until_idle(200);

    // Boundaries: odd final step, equal target, simultaneous requests.
    do_reset();
    drv_req = 1'b1; drv_limit = 8'd81;
    run_cycle();
    repeat (4) run_cycle();
    check("no_overshoot", speed_limit, 8'd81);
    check("no_overshoot_busy", busy, 1'b0);
    run_cycle();
    drv_req = 1'b1; drv_limit = 8'd81;
    run_cycle();
    check("equal_ack", drv_ack, 1'b1);
    check("equal_busy", busy, 1'b0);
    run_cycle();
    check("equal_owner", owner, 2'b00);
    drv_req = 1'b1; drv_limit = 8'd90;
    sign_req = 1'b1; sign_limit = 8'd70;
    run_cycle();
    check("simul_acks", {drv_ack, sign_ack}, 2'b01);
    wait_ack(0, 200);
    run_until_idle(200);

    // Emergency drop is immediate; a concurrent sign waits for release.
    do_reset();
    emg_req = 1'b1; emg_limit = 8'd30;
    sign_req = 1'b1; sign_limit = 8'd70;
    run_cycle();
    check("emg_load", speed_limit, 8'd30);
    check("emg_owner", owner, 2'b11);
    repeat (10) run_cycle();
    emg_req = 1'b0;
    run_cycle();
    run_cycle();
    check("sign_after_emg", sign_ack, 1'b1);
    run_until_idle(200);

    // Reset in the middle of a ramp.
    drv_req = 1'b1; drv_limit = 8'd120;
    repeat (6) run_cycle();
    do_reset();

    // Randomized requesters.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        if (!drv_req && $urandom_range(0, 15) == 0) begin
          drv_req = 1'b1; drv_limit = 8'($urandom_range(20, 140));
        end
        if (!sign_req && $urandom_range(0, 23) == 0) begin
          sign_req = 1'b1; sign_limit = 8'($urandom_range(20, 140));
        end
        if (emg_req) begin
          if (emg_left > 0) emg_left--;
          else emg_req = 1'b0;
        end else if ($urandom_range(0, 199) == 0) begin
          emg_req = 1'b1; emg_limit = 8'($urandom_range(20, 140));
          emg_left = int'($urandom_range(3, 60));
        end
        run_cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
